if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
Decoupling instruction buffer between the fetch stage and the decode stage. It accepts fetched {pc, instr} pairs on a valid/ready handshake and holds them in a small circular FIFO. It presents the oldest entry to decode, with the standard RV32I fields pre-sliced (opcode feeds the type decoder directly). It absorbs decode stalls without a combinational ready path back to fetch, and supports a single-cycle flush on redirect.

Parameters:
XLEN, 32, width of pc and instruction words.
DEPTH, 2, number of entries; power of two, minimum 2.
NOP_INSTR, 32'h00000013, instruction word presented when the buffer is empty (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  discard all entries (branch/jump redirect).
in_valid  input  1  fetch offers an entry.
in_ready  output  1  buffer can accept an entry.
in_pc  input  XLEN  pc of offered instruction.
in_instr  input  XLEN  offered instruction word.
out_valid  output  1  head entry valid.
out_ready  input  1  decode consumes head.
out_pc  output  XLEN  head pc.
out_instr  output  XLEN  head instruction, or NOP_INSTR when empty.
out_opcode  output  7  out_instr[6:0].
out_rd  output  5  out_instr[11:7].
out_funct3  output  3  out_instr[14:12].
out_rs1  output  5  out_instr[19:15].
out_rs2  output  5  out_instr[24:20].
out_funct7  output  7  out_instr[31:25].
count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry array of {pc, instr}; write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is registered-state-only and must never depend on out_ready. A full buffer therefore refuses a push even in a cycle where it pops.
- out_valid = (count != 0). out_pc and out_instr are read combinationally from entry rd_ptr.
- When empty: out_instr = NOP_INSTR and out_pc = 0, so all field outputs decode as addi x0,x0,0.
- Field outputs are pure slices of out_instr; they carry no extra logic.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no same-cycle bypass from in_* to out_*.
- Counter update: push only gives count+1; pop only gives count-1; push and pop together leave count unchanged while both pointers advance.
- Wrap-around: a pointer at DEPTH-1 advances to 0.
- flush (synchronous, highest priority): at the next edge count, wr_ptr and rd_ptr go to 0.
  - A push or pop in the flush cycle is ignored, and the offered entry is dropped.
  - Array contents need not clear.
  - in_ready and out_valid still reflect pre-flush state during the flush cycle.
- Reset (async, rst_n low): count=0 and pointers=0 immediately, so out_valid=0, in_ready=1, out_instr=NOP_INSTR and out_pc=0. Array contents are not reset. Reset asserted mid-transfer drops all entries.
- Stable-hold rule: while out_valid=1 and out_ready=0, out_* must not change.
- Fetch must hold in_pc/in_instr stable while in_valid=1 and in_ready=0. The buffer does not check this.

Decomposition:
- Shared package/include: opcode constants (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC), NOP_INSTR value, and field bit-position constants. The decoder and this block use the same constants.
- One natural sub-module: if_id_fifo_mem, a DEPTH x (2*XLEN) register array with one write port and one combinational read port. The top holds pointers, count, flush and field slicing.

Test Plan:
1. Reset → out_valid=0, in_ready=1, count=0, out_instr=0x00000013, out_opcode=0x13, out_rd=0.
2. Push pc=0x100/instr=0x00500093 with out_ready=0 → after one edge: out_valid=1, out_opcode=0x13, out_rd=1, out_rs1=0, count=1. Push pc=0x104 → count=2, in_ready=0. A third push is refused and out_pc stays 0x100.
3. Full buffer, out_ready=1 and in_valid=1 for one cycle → only the pop happens: count=1, out_pc=0x104, in_ready=1.
4. Streaming 6 instructions at 0x200 + 4k with in_valid=out_ready=1 every cycle → count stays 1. Outputs appear in order with one-cycle latency, and pointers wrap without loss or duplication.
5. Two entries held, then flush=1 with in_valid=1 (pc=0x300) → next cycle count=0, out_valid=0, out_instr=0x13. Entry 0x300 is never output.
6. Reset asserted asynchronously mid-stream with two entries → outputs drop to reset values before the next clock edge. After release, the first push appears normally.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared RV32I constants for the fetch/decode boundary.
// Holds the major opcodes, the canonical NOP encoding, the instruction field
// bit positions and a packed view of a base-format instruction word. The decoder
// uses these same definitions.
package if_id_buffer_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // addi x0,x0,0
  localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

  // Field bit positions (LSB) and widths
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned INSTR_W  = 32;

  // R-type view of an instruction word; the layout follows the LSB constants above
  typedef struct packed {
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rs1;
    logic [FUNCT3_W-1:0] funct3;
    logic [REG_W-1:0]    rd;
    logic [OPCODE_W-1:0] opcode;
  } rv_instr_t;

endpackage

// File: rtl/if_id_buffer_if.sv
// Fetch/decode handshake bundle for if_id_buffer.
// Carries the flush and fetch-side signals (flush, in_valid/in_ready/in_pc/in_instr)
// and the decode-side signals (out_valid/out_ready, out_pc/out_instr, the pre-sliced
// fields, count).
// Modports: slave = the buffer, master = the environment driving both sides.
interface if_id_buffer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
);
  import if_id_buffer_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     in_pc;
  logic [XLEN-1:0]     in_instr;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_instr;
  logic [OPCODE_W-1:0] out_opcode;
  logic [REG_W-1:0]    out_rd;
  logic [FUNCT3_W-1:0] out_funct3;
  logic [REG_W-1:0]    out_rs1;
  logic [REG_W-1:0]    out_rs2;
  logic [FUNCT7_W-1:0] out_funct7;
  logic [CW-1:0]       count;

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7, count
  );

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr,
           out_opcode, out_rd, out_funct3, out_rs1, out_rs2, out_funct7, count
  );

endinterface

// File: rtl/if_id_fifo_mem.sv
// Register array for the fetch/decode buffer: DEPTH x W, one synchronous write
// port and one combinational read port. Contents are deliberately not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module if_id_fifo_mem #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned W     = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// Decoupling instruction buffer between fetch and decode.
// Circular FIFO of {pc, instr}; the head entry is presented to decode with the
// RV32I fields pre-sliced. in_ready depends only on occupancy, so there is no
// combinational path from out_ready back to fetch. flush empties the buffer at
// the next edge.
// Ports: clk, rst_n (async, active low), bus (if_id_buffer_if.slave).
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(RV_NOP_INSTR)
) (
  input  logic          clk,
  input  logic          rst_n,
  if_id_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 2 * XLEN;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic          not_empty;
  logic          not_full;
  logic [DW-1:0] head;
  logic [XLEN-1:0] head_instr;
  rv_instr_t     fields;

  assign not_full  = (count_q != CW'(DEPTH));
  assign not_empty = (count_q != CW'(0));
  assign push      = bus.in_valid && not_full;
  assign pop       = not_empty && bus.out_ready;

  // Pointer/count next state; flush overrides any push or pop in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = PW'(wr_ptr_q + PW'(1));
      end
      if (pop) begin
        rd_ptr_d = PW'(rd_ptr_q + PW'(1));
      end
      case ({push, pop})
        2'b10:   count_d = CW'(count_q + CW'(1));
        2'b01:   count_d = CW'(count_q - CW'(1));
        default: count_d = count_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; a push dropped by flush must not land in the array
  if_id_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (DW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !bus.flush),
    .waddr (wr_ptr_q),
    .wdata ({bus.in_pc, bus.in_instr}),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  // Empty buffer shows a NOP at pc 0 so downstream decode sees a harmless instruction
  assign head_instr = not_empty ? head[XLEN-1:0] : NOP_INSTR;

  assign bus.in_ready  = not_full;
  assign bus.out_valid = not_empty;
  assign bus.out_pc    = not_empty ? head[DW-1:XLEN] : '0;
  assign bus.out_instr = head_instr;
  assign bus.count     = count_q;

  // Field slices of the presented word
  assign fields         = rv_instr_t'(head_instr[INSTR_W-1:0]);
  assign bus.out_opcode = fields.opcode;
  assign bus.out_rd     = fields.rd;
  assign bus.out_funct3 = fields.funct3;
  assign bus.out_rs1    = fields.rs1;
  assign bus.out_rs2    = fields.rs2;
  assign bus.out_funct7 = fields.funct7;

endmodule
